serial_subtractor_14: RTL and testbench
=======================================

// Module: serial_subtractor_14
// PURPOSE
//  Bit-serial unsigned subtractor: computes A - B one bit per clock through a single
//  full-subtractor cell and a registered borrow. It is the inverse arithmetic path of
//  the 14-bit ripple-carry adder, and produces difference, borrow/sign and magnitude
//  for the calculator datapath and display stage. It uses a start/done handshake and
//  trades latency for area.
// PARAMETERS
//  WIDTH  14  operand/result width in bits (>=2); counter width = clog2(WIDTH+1)
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend (unsigned); sampled when start is accepted
//  b      in   WIDTH  subtrahend (unsigned); sampled when start is accepted
//  busy   out  1      high in SHIFT and FIX states
//  done   out  1      one-cycle pulse; results valid from this cycle
//  diff   out  WIDTH  (a - b) mod 2^WIDTH
//  borrow out  1      1 iff a < b (final borrow out of MSB)
//  neg    out  1      sign of true result; equals borrow
//  mag    out  WIDTH  |a - b| as unsigned
// BEHAVIOUR
//  Reset: rst=1 at an edge -> state IDLE; busy=0, done=0, diff=0, borrow=0, neg=0,
//   mag=0; internal shift regs, borrow flop and bit counter = 0. Reset wins over
//   every other event. Reset mid-operation aborts it, and no done is issued.
//  FSM: IDLE -> SHIFT -> FIX -> DONE -> IDLE.
//   IDLE: start=1 -> latch a,b into shift regs, borrow flop=0, cnt=0, go SHIFT.
//         start=0 -> stay. Outputs hold the previous result.
//   SHIFT: each cycle: d_i = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br);
//          shift d_i into MSB of result reg (LSB first); cnt++. After WIDTH cycles
//          (cnt==WIDTH-1 at edge) -> FIX.
//   FIX:   diff <= result reg; borrow <= br; neg <= br;
//          mag <= br ? (~result + 1) : result  (mod 2^WIDTH) -> DONE.
//   DONE:  done=1 for exactly this cycle, busy=0 -> IDLE.
//  Latency: start accepted at edge T -> done high in cycle T+WIDTH+2 (16 for W=14).
//   Next start is accepted no earlier than the cycle after done.
//  start while busy or in DONE: ignored, not queued; the operation in flight is unchanged.
//  Operands a/b may change freely after acceptance without effect.
//  diff/borrow/neg/mag update only in FIX and stay stable until the next FIX or rst.
//  Edge cases: a==b -> diff=0, borrow=0, mag=0. a=0,b=2^W-1 -> diff=1, borrow=1, mag=2^W-1.
// TESTING
//  1 a=5000,b=1234,start pulse -> done at +16, diff=3766, borrow=0, neg=0, mag=3766
//  2 a=1234,b=5000 -> diff=12618, borrow=1, neg=1, mag=3766
//  3 a=0,b=1 -> diff=16383, borrow=1, mag=1; a=16383,b=0 -> diff=16383, borrow=0, mag=16383
//  4 a=b=9999 -> diff=0, borrow=0, mag=0; busy high for 15 cycles, done exactly 1 cycle
//  5 start again at +5 with a=1,b=2 during op (7,3) -> ignored; result diff=4, one done only
//  6 rst at +8 of op (100,1) -> next cycle all outputs 0, IDLE, no done;
//    new start (100,1) -> diff=99
//  Also: random a/b (1000 ops) vs reference model (a-b)&16383, a<b, abs(a-b)

Source files
------------

// File: rtl/serial_subtractor_14.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, registered borrow.
// Yields diff, borrow/sign and magnitude after a start/done handshake.
module serial_subtractor_14 #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             neg,
  output logic [WIDTH-1:0] mag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  logic br;
  logic ai, bi, di, br_n;

  assign ai   = sa[0];
  assign bi   = sb[0];
  assign di   = ai ^ bi ^ br;
  assign br_n = (~ai & bi) | (~(ai ^ bi) & br);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands shift out LSB first; difference bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      neg    <= 1'b0;
      mag    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {di, res[WIDTH-1:1]};
          br  <= br_n;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          diff   <= res;
          borrow <= br;
          neg    <= br;
          mag    <= br ? (~res + WIDTH'(1)) : res;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_14.sv
// Bench for serial_subtractor_14: timeline reference model checked every
// cycle, plus directed literal cases and randomized operations.
module tb_serial_subtractor_14;

  localparam int W    = 14;
  localparam int MASK = (1 << W) - 1;
  localparam int LAT  = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, neg;
  logic [W-1:0] diff, mag;

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  // reference model state
  int left = 0;
  int m_diff = 0, m_br = 0, m_mag = 0;
  int p_diff = 0, p_br = 0, p_mag = 0;

  always #5 clk = ~clk;

  serial_subtractor_14 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .neg(neg), .mag(mag)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // left counts edges remaining until idle; result lands when left hits 1
  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      m_diff = 0; m_br = 0; m_mag = 0;
    end else if (left == 0) begin
      if (start) begin
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        p_diff = (ia - ib) & MASK;
        p_br   = (ia < ib) ? 1 : 0;
        p_mag  = (ia >= ib) ? ia - ib : ib - ia;
        left   = LAT;
      end
    end else begin
      left--;
      if (left == 1) begin
        m_diff = p_diff; m_br = p_br; m_mag = p_mag;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   int'(busy),   (left >= 2) ? 1 : 0);
      chk("done",   int'(done),   (left == 1) ? 1 : 0);
      chk("diff",   int'(diff),   m_diff);
      chk("borrow", int'(borrow), m_br);
      chk("neg",    int'(neg),    m_br);
      chk("mag",    int'(mag),    m_mag);
    end
  end

  // drive a one-cycle start; returns at the negedge after the accept edge
  task automatic start_op(input int va, input int vb);
    @(negedge clk);
    a = W'(va);
    b = W'(vb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts edges since accept (accept edge = 1); nb counts busy cycles
  task automatic wait_done(input int n0, output int n, output int nb, input bit noise);
    n = n0;
    nb = busy ? 1 : 0;
    while (!done && n < 100) begin
      if (noise && ($urandom_range(0, 3) == 0)) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
  endtask

  task automatic directed(input string nm, input int va, input int vb,
                          input int ed, input int eb, input int em);
    int n, nb;
    start_op(va, vb);
    wait_done(1, n, nb, 1'b0);
    chk({nm, "_lat"}, n, LAT);
    chk({nm, "_diff"}, int'(diff), ed);
    chk({nm, "_borrow"}, int'(borrow), eb);
    chk({nm, "_neg"}, int'(neg), eb);
    chk({nm, "_mag"}, int'(mag), em);
  endtask

  initial begin
    int n, nb, dn;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_mag",  int'(mag),  0);
    rst = 1'b0;
    chk_en = 1'b1;

    directed("t1", 5000, 1234, 3766, 0, 3766);
    directed("t2", 1234, 5000, 12618, 1, 3766);
    directed("t3a", 0, 1, 16383, 1, 1);
    directed("t3b", 16383, 0, 16383, 0, 16383);
    directed("t3c", 0, 16383, 1, 1, 16383);

    // equal operands: busy width and single done
    start_op(9999, 9999);
    wait_done(1, n, nb, 1'b0);
    chk("t4_busy_cycles", nb, W + 1);
    chk("t4_diff", int'(diff), 0);
    chk("t4_mag", int'(mag), 0);
    @(negedge clk);
    chk("t4_done_pulse", int'(done), 0);

    // start during an operation is ignored
    start_op(7, 3);
    repeat (3) @(negedge clk);
    a = W'(1);
    b = W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n, nb, 1'b0);
    chk("t5_lat", n, LAT);
    chk("t5_diff", int'(diff), 4);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t5_extra_done", dn, 0);

    // reset mid-operation aborts without a done
    start_op(100, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_diff", int'(diff), 0);
    chk("t6_borrow", int'(borrow), 0);
    chk("t6_mag", int'(mag), 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t6_no_done", dn, 0);
    directed("t6b", 100, 1, 99, 0, 99);

    // randomized operations with ignored start noise while busy
    for (int i = 0; i < 1000; i++) begin
      int ra, rb;
      ra = $urandom_range(0, MASK);
      rb = (i % 10 == 0) ? ra : $urandom_range(0, MASK);
      start_op(ra, rb);
      wait_done(1, n, nb, 1'b1);
      chk("rnd_lat", n, LAT);
      chk("rnd_diff", int'(diff), (ra - rb) & MASK);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
